// File: rtl/wifi_scr_pkg.sv
// Shared constants and types for the 802.11a frame scrambler, S(x) = x^7 + x^4 + 1.
// State vectors are packed as state[i] = x(i+1), so x7 is the MSB.
package wifi_scr_pkg;

  localparam int SCR_LEN = 7;

  // Feedback taps x7 and x4 as a mask over the packed state (bits 6 and 3).
  localparam logic [SCR_LEN-1:0] SCR_POLY_TAPS = 7'b100_1000;

  localparam logic [SCR_LEN-1:0] SCR_DFLT_SEED = 7'h7F;

  // rx_cnt value at which the receiver has taken all seven SERVICE bits.
  localparam logic [2:0] SCR_CNT_FULL = 3'd7;

  typedef enum logic {
    SCR_TX = 1'b0,
    SCR_RX = 1'b1
  } scr_mode_e;

  // An all-zero LFSR state never leaves zero, so a zero seed is replaced.
  function automatic logic [SCR_LEN-1:0] scr_seed_fix(
    input logic [SCR_LEN-1:0] seed,
    input logic [SCR_LEN-1:0] dflt
  );
    return (seed == '0) ? dflt : seed;
  endfunction

endpackage

// File: rtl/scr_lfsr_step.sv
// Combinational DATA_W-bit unroll of the scrambler LFSR for one beat.
// Bit 0 of data is the earliest bit in air order and is processed first.
// In RX mode, while cnt < 7, received bits are loaded directly into the
// state (they are keystream, since the SERVICE plaintext is zero) and the
// output bit is forced to 0; once cnt reaches 7 the remaining bits of the
// same beat are descrambled with the recovered state.
module scr_lfsr_step
  import wifi_scr_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [SCR_LEN-1:0] state,
  input  logic [DATA_W-1:0]  data,
  input  logic [2:0]         cnt,
  input  logic               mode,
  output logic [SCR_LEN-1:0] next_state,
  output logic [DATA_W-1:0]  dout,
  output logic [2:0]         next_cnt,
  output logic               recovered,
  output logic [SCR_LEN-1:0] rec_state
);

  logic [SCR_LEN-1:0] s;
  logic [2:0]         c;
  logic               k;

  // Walk the beat bit by bit, chaining the state through the unroll.
  always_comb begin
    s          = state;
    c          = cnt;
    k          = 1'b0;
    dout       = '0;
    recovered  = 1'b0;
    rec_state  = '0;
    for (int j = 0; j < DATA_W; j++) begin
      if ((mode == SCR_RX) && (c != SCR_CNT_FULL)) begin
        s       = {s[SCR_LEN-2:0], data[j]};
        dout[j] = 1'b0;
        c       = c + 3'd1;
        if (c == SCR_CNT_FULL) begin
          recovered = 1'b1;
          rec_state = s;
        end
      end else begin
        k       = ^(s & SCR_POLY_TAPS);
        dout[j] = data[j] ^ k;
        s       = {s[SCR_LEN-2:0], k};
      end
    end
    next_state = s;
    next_cnt   = c;
  end

endmodule

// File: rtl/parallel_scrambler.sv
// 802.11a scrambler (TX) / self-synchronising descrambler (RX), DATA_W bits
// per clock. Holds the LFSR, mode, SERVICE-bit counter, lock flag and the
// registered output stage; the per-beat bit unroll lives in scr_lfsr_step.
//
// Handshake: an input beat transfers on a rising edge where
// In_valid & In_ready; an output beat transfers where Out_valid & Out_ready
// while En is high. In_ready = En & (~Out_valid | Out_ready), so an output
// beat is replaced in the same cycle it is consumed. En low freezes
// everything, including the output register, so a held beat is neither
// consumed nor lost while En is low. Out holds while Out_valid & ~Out_ready.
module parallel_scrambler
  import wifi_scr_pkg::*;
#(
  parameter int                 DATA_W    = 8,
  parameter logic [SCR_LEN-1:0] DFLT_SEED = SCR_DFLT_SEED
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic              Mode,
  input  logic              Start,
  input  logic [6:0]        Seed,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [DATA_W-1:0] Data,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [DATA_W-1:0] Out,
  output logic              Locked,
  output logic              Sync_err
);

  logic [SCR_LEN-1:0] lfsr;
  scr_mode_e          mode_q;
  logic [2:0]         rx_cnt;

  logic               accept;
  logic               start_go;

  // State as seen by the current beat, after folding in a same-cycle Start.
  logic [SCR_LEN-1:0] eff_state;
  scr_mode_e          eff_mode;
  logic [2:0]         eff_cnt;
  logic               eff_locked;

  logic [SCR_LEN-1:0] step_state;
  logic [DATA_W-1:0]  step_dout;
  logic [2:0]         step_cnt;
  logic               step_rec;
  logic [SCR_LEN-1:0] step_rec_state;

  logic               rec_good;
  logic               rec_zero;

  assign In_ready = En & (~Out_valid | Out_ready);
  assign accept   = In_valid & In_ready;
  assign start_go = En & Start;

  assign rec_good = accept & step_rec & (step_rec_state != '0);
  assign rec_zero = accept & step_rec & (step_rec_state == '0);

  // A Start takes effect on the beat accepted in the same cycle.
  always_comb begin
    eff_state  = lfsr;
    eff_mode   = mode_q;
    eff_cnt    = rx_cnt;
    eff_locked = Locked;
    if (start_go) begin
      eff_mode = scr_mode_e'(Mode);
      eff_cnt  = '0;
      if (scr_mode_e'(Mode) == SCR_TX) begin
        eff_state  = scr_seed_fix(Seed, DFLT_SEED);
        eff_locked = 1'b1;
      end else begin
        eff_locked = 1'b0;
      end
    end
  end

  scr_lfsr_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .state      (eff_state),
    .data       (Data),
    .cnt        (eff_cnt),
    .mode       (eff_mode),
    .next_state (step_state),
    .dout       (step_dout),
    .next_cnt   (step_cnt),
    .recovered  (step_rec),
    .rec_state  (step_rec_state)
  );

  // LFSR, mode and counter advance only on accepted beats; Start alone just loads/arms.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr   <= SCR_DFLT_SEED;
      mode_q <= SCR_TX;
      rx_cnt <= '0;
      Locked <= 1'b0;
    end else if (En) begin
      mode_q <= eff_mode;
      lfsr   <= accept ? step_state : eff_state;
      rx_cnt <= accept ? step_cnt : eff_cnt;
      if (rec_good) begin
        Locked <= 1'b1;
      end else begin
        Locked <= eff_locked;
      end
    end
  end

  // Output register: load on accept, drop valid when consumed, hold when stalled.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Out       <= '0;
      Out_valid <= 1'b0;
    end else if (En) begin
      if (accept) begin
        Out       <= step_dout;
        Out_valid <= 1'b1;
      end else if (Out_ready) begin
        Out_valid <= 1'b0;
      end
    end
  end

  // Single-cycle flag when the recovered RX state is all zero (LFSR stays 0).
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Sync_err <= 1'b0;
    end else begin
      Sync_err <= rec_zero;
    end
  end

endmodule

// File: tb/tb_parallel_scrambler.sv
// Directed bench for parallel_scrambler (DATA_W=8): TX from seed, zero-seed
// substitution, RX seed recovery, all-zero recovery error, random output
// stalls with En dropouts, and reset mid-frame.
module tb_parallel_scrambler;
  import wifi_scr_pkg::*;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         En = 1'b1;
  logic         Mode = 1'b0;
  logic         Start = 1'b0;
  logic [6:0]   Seed = 7'h00;
  logic         In_valid = 1'b0;
  logic         In_ready;
  logic [W-1:0] Data = '0;
  logic         Out_valid;
  logic         Out_ready = 1'b1;
  logic [W-1:0] Out;
  logic         Locked;
  logic         Sync_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic         ks [0:1023];
  logic [7:0]   hand [0:3];
  int           sync_cnt = 0;
  logic         rand_on = 1'b0;
  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_val = '0;

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  parallel_scrambler #(
    .DATA_W (W)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .En        (En),
    .Mode      (Mode),
    .Start     (Start),
    .Seed      (Seed),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .Data      (Data),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Out       (Out),
    .Locked    (Locked),
    .Sync_err  (Sync_err)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Keystream of the x^7+x^4+1 generator: a[0..6] hold x7..x1 of the seed,
  // and every later bit is a[n] ^ a[n+3] (i.e. s_n = s_(n-7) ^ s_(n-4)).
  task automatic build_ks(input logic [6:0] seed);
    logic a [0:1030];
    for (int i = 1; i <= 7; i++) a[7-i] = seed[i-1];
    for (int n = 0; n < 1024; n++) begin
      a[n+7] = a[n] ^ a[n+3];
      ks[n]  = a[n+7];
    end
  endtask

  function automatic logic [W-1:0] ks_byte(input int idx);
    logic [W-1:0] b;
    for (int j = 0; j < W; j++) b[j] = ks[idx+j];
    return b;
  endfunction

  // One clock: sample/score outputs at negedge, then advance past posedge.
  task automatic tick(output logic acc);
    @(negedge Clk);
    if (Sync_err) sync_cnt++;
    if (!Reset) begin
      if (hold_pend) check("hold", {23'b0, Out_valid, Out}, {23'b0, 1'b1, hold_val});
      if (En && Out_valid && Out_ready) begin
        if (exp_q.size() == 0) check("beat_count", 32'(exp_q.size()), 32'd1);
        else check("out_beat", 32'(Out), 32'(exp_q.pop_front()));
      end
      hold_pend = Out_valid && !(Out_ready && En);
      hold_val  = Out;
    end else begin
      hold_pend = 1'b0;
    end
    acc = In_valid & In_ready;
    @(posedge Clk);
    #1;
    if (rand_on) begin
      Out_ready = 1'($urandom_range(0, 1));
      En        = ($urandom_range(0, 3) != 0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [W-1:0] d, input logic st, input logic md,
                      input logic [6:0] sd, input logic [W-1:0] e);
    logic acc;
    acc      = 1'b0;
    Data     = d;
    In_valid = 1'b1;
    Start    = st;
    Mode     = md;
    Seed     = sd;
    for (int g = 0; g < 200 && !acc; g++) begin
      tick(acc);
      Start = 1'b0;
      if (acc) exp_q.push_back(e);
    end
    In_valid = 1'b0;
    check("accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int g = 0; g < 500 && exp_q.size() != 0; g++) tick(acc);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic         acc;
    logic [W-1:0] d;
    int           ki;

    hand[0] = 8'h70; hand[1] = 8'h4F; hand[2] = 8'h93; hand[3] = 8'h40;
    build_ks(7'h7F);

    // reset state
    repeat (3) tick(acc);
    check("rst_out", 32'(Out), 32'd0);
    check("rst_out_valid", 32'(Out_valid), 32'd0);
    check("rst_locked", 32'(Locked), 32'd0);
    check("rst_sync_err", 32'(Sync_err), 32'd0);
    check("rst_in_ready", 32'(In_ready), 32'd1);
    Reset = 1'b0;
    tick(acc);

    // 1: TX, Seed 7F, zero data; first beats against the hand sequence
    ki = 0;
    for (int b = 0; b < 16; b++) begin
      send('0, (b == 0), 1'b0, 7'h7F, (b < 4) ? hand[b] : ks_byte(ki));
      ki += W;
      if (b == 0) check("tx_locked", 32'(Locked), 32'd1);
    end
    drain();

    // 2: TX, Seed 0 -> default seed, mixed data
    ki = 0;
    for (int b = 0; b < 16; b++) begin
      d = W'(b * 29 + 3);
      send(d, (b == 0), 1'b0, 7'h00, d ^ ks_byte(ki));
      ki += W;
    end
    drain();
    // Start while En low is ignored: TX keystream continues
    En = 1'b0; Start = 1'b1; Mode = 1'b1; Seed = 7'h11;
    tick(acc);
    Start = 1'b0; En = 1'b1;
    for (int b = 0; b < 2; b++) begin
      d = W'(8'hC3 + b);
      send(d, 1'b0, 1'b0, 7'h00, d ^ ks_byte(ki));
      ki += W;
    end
    drain();
    check("en0_start_locked", 32'(Locked), 32'd1);

    // 3: RX on the scenario-1 stream -> all zero, locks in the first beat
    sync_cnt = 0;
    for (int b = 0; b < 16; b++) begin
      send(ks_byte(b * W), (b == 0), 1'b1, 7'h00, '0);
      if (b == 0) check("rx_locked", 32'(Locked), 32'd1);
    end
    drain();
    tick(acc);
    check("rx_no_sync_err", 32'(sync_cnt), 32'd0);

    // 4: RX with seven zero SERVICE bits -> sync error, pass-through
    sync_cnt = 0;
    send(8'h80, 1'b1, 1'b1, 7'h00, 8'h80);
    send(8'hA5, 1'b0, 1'b1, 7'h00, 8'hA5);
    send(8'h3C, 1'b0, 1'b1, 7'h00, 8'h3C);
    send(8'hFF, 1'b0, 1'b1, 7'h00, 8'hFF);
    drain();
    tick(acc);
    check("zero_sync_err", 32'(sync_cnt), 32'd1);
    check("zero_locked", 32'(Locked), 32'd0);

    // 5: TX with random output stalls and En dropouts
    ki = 0;
    send('0, 1'b1, 1'b0, 7'h7F, ks_byte(ki));
    ki += W;
    rand_on = 1'b1;
    for (int b = 0; b < 40; b++) begin
      d = W'($urandom_range(0, 255));
      send(d, 1'b0, 1'b0, 7'h00, d ^ ks_byte(ki));
      ki += W;
    end
    drain();
    rand_on = 1'b0;
    @(posedge Clk);
    #2;
    En = 1'b1; Out_ready = 1'b1;
    tick(acc);

    // 6: reset mid-frame, then restart from Seed 7F
    ki = 0;
    for (int b = 0; b < 3; b++) begin
      send('0, (b == 0), 1'b0, 7'h7F, ks_byte(ki));
      ki += W;
    end
    #2;
    Reset = 1'b1;
    #1;
    check("midrst_out", 32'(Out), 32'd0);
    check("midrst_out_valid", 32'(Out_valid), 32'd0);
    check("midrst_locked", 32'(Locked), 32'd0);
    exp_q.delete();
    tick(acc);
    tick(acc);
    Reset = 1'b0;
    tick(acc);
    check("postrst_locked", 32'(Locked), 32'd0);
    ki = 0;
    for (int b = 0; b < 4; b++) begin
      send('0, (b == 0), 1'b0, 7'h7F, (b == 0) ? hand[0] : ks_byte(ki));
      ki += W;
    end
    drain();

    repeat (3) tick(acc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global bound on the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
